// File: rtl/uart_engine.sv
// ============================================================================
// uart_engine -- full-duplex UART transmitter and receiver.
//
// The receiver and the transmitter are independent state machines that share
// only the clock and the reset. Frame format: one start bit (low), DATA_BITS
// data bits LSB first, an optional parity bit, then STOP_BITS stop bits (high).
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 4)
//   DATA_BITS     data bits per frame (5..8)
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   uartRx         serial input, asynchronous, idle high
//   uartTx         serial output, registered, idle high
//   tx_data        word to transmit, captured on the handshake
//   tx_valid       tx_data is valid
//   tx_ready       transmitter can accept a word (handshake = valid && ready)
//   rx_data        last received word
//   rx_valid       one-cycle pulse: rx_data and the error flags were updated
//   rx_parity_err  parity mismatch on the last frame
//   rx_frame_err   a stop bit was sampled low on the last frame
//   rx_busy        receiver is not idle
//   tx_busy        transmitter is not idle
// ============================================================================
module uart_engine #(
   parameter int CLKS_PER_BIT = 234,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 uartRx,
   output logic                 uartTx,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_busy,
   output logic                 tx_busy
);

   // Counter holds 0..CLKS_PER_BIT-1 and is cleared at every bit boundary,
   // so it never wraps inside a bit.
   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
   localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // Value the parity bit must carry for the given data word.
   function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
      if (PARITY == 1) return ~(^d);
      return ^d;
   endfunction

   // -------------------------------------------------------------------------
   // Receiver
   // -------------------------------------------------------------------------
   logic                 rx_meta;
   logic                 rx_sync;
   logic                 rx_sync_d;
   state_t               rx_state;
   logic [CNT_W-1:0]     rx_cnt;
   logic [2:0]           rx_idx;
   logic [DATA_BITS-1:0] rx_shift;
   logic                 perr_acc;
   logic                 ferr_acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: synchroniser flops reset to the idle line level so leaving
         // reset can never look like a falling start edge.
         rx_meta       <= 1'b1;
         rx_sync       <= 1'b1;
         rx_sync_d     <= 1'b1;
         rx_state      <= S_IDLE;
         rx_cnt        <= '0;
         rx_idx        <= '0;
         rx_shift      <= '0;
         perr_acc      <= 1'b0;
         ferr_acc      <= 1'b0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every flop here
         // samples the pre-edge value of the one feeding it (a true 2-flop
         // synchroniser plus an edge-detect delay stage).
         rx_meta   <= uartRx;
         rx_sync   <= rx_meta;
         rx_sync_d <= rx_sync;
         rx_valid  <= 1'b0;

         case (rx_state)
            S_IDLE: begin
               if (rx_sync_d && !rx_sync) begin
                  rx_state <= S_START;
                  rx_cnt   <= '0;
               end
            end

            // Sample mid start bit; a high level here was only a glitch.
            S_START: begin
               if (rx_cnt == BIT_HALF) begin
                  rx_cnt   <= '0;
                  rx_idx   <= '0;
                  perr_acc <= 1'b0;
                  ferr_acc <= 1'b0;
                  rx_state <= rx_sync ? S_IDLE : S_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (rx_cnt == BIT_END) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                  if (rx_idx == DATA_LAST) begin
                     rx_idx   <= '0;
                     rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     rx_idx <= rx_idx + 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end

            S_PARITY: begin
               if (rx_cnt == BIT_END) begin
                  rx_cnt   <= '0;
                  rx_idx   <= '0;
                  perr_acc <= (rx_sync != parity_of(rx_shift));
                  rx_state <= S_STOP;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end

            // Any low stop sample marks a frame error; the word is still
            // delivered with rx_valid.
            S_STOP: begin
               if (rx_cnt == BIT_END) begin
                  rx_cnt <= '0;
                  if (rx_idx == STOP_LAST) begin
                     rx_data       <= rx_shift;
                     rx_parity_err <= perr_acc;
                     rx_frame_err  <= ferr_acc | ~rx_sync;
                     rx_valid      <= 1'b1;
                     rx_state      <= S_IDLE;
                  end else begin
                     ferr_acc <= ferr_acc | ~rx_sync;
                     rx_idx   <= rx_idx + 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end

            default: rx_state <= S_IDLE;
         endcase
      end
   end

   assign rx_busy = (rx_state != S_IDLE);

   // -------------------------------------------------------------------------
   // Transmitter
   // -------------------------------------------------------------------------
   state_t               tx_state;
   logic [CNT_W-1:0]     tx_cnt;
   logic [2:0]           tx_idx;
   logic [DATA_BITS-1:0] tx_shift;
   logic                 tx_par;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_shift <= '0;
         tx_par   <= 1'b0;
         uartTx   <= 1'b1;
         tx_ready <= 1'b0;
      end else begin
         case (tx_state)
            S_IDLE: begin
               uartTx <= 1'b1;
               if (tx_valid && tx_ready) begin
                  tx_shift <= tx_data;
                  tx_par   <= parity_of(tx_data);
                  uartTx   <= 1'b0;
                  tx_cnt   <= '0;
                  tx_ready <= 1'b0;
                  tx_state <= S_START;
               end else begin
                  tx_ready <= 1'b1;
               end
            end

            // The line value for the next bit is loaded at the last cycle of
            // the current one so uartTx always comes straight from a flop.
            S_START: begin
               if (tx_cnt == BIT_END) begin
                  tx_cnt   <= '0;
                  tx_idx   <= '0;
                  uartTx   <= tx_shift[0];
                  tx_shift <= tx_shift >> 1;
                  tx_state <= S_DATA;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (tx_cnt == BIT_END) begin
                  tx_cnt <= '0;
                  if (tx_idx == DATA_LAST) begin
                     tx_idx <= '0;
                     if (PARITY != 0) begin
                        uartTx   <= tx_par;
                        tx_state <= S_PARITY;
                     end else begin
                        uartTx   <= 1'b1;
                        tx_state <= S_STOP;
                     end
                  end else begin
                     tx_idx   <= tx_idx + 1'b1;
                     uartTx   <= tx_shift[0];
                     tx_shift <= tx_shift >> 1;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end

            S_PARITY: begin
               if (tx_cnt == BIT_END) begin
                  tx_cnt   <= '0;
                  tx_idx   <= '0;
                  uartTx   <= 1'b1;
                  tx_state <= S_STOP;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end

            // IDLE is entered for the final cycle of the last stop bit (the
            // line is already high), so a handshake on that cycle starts the
            // next frame with no gap beyond the stop bits.
            S_STOP: begin
               if (tx_idx == STOP_LAST && tx_cnt == BIT_PRE) begin
                  tx_cnt   <= '0;
                  tx_ready <= 1'b1;
                  tx_state <= S_IDLE;
               end else if (tx_cnt == BIT_END) begin
                  tx_cnt <= '0;
                  tx_idx <= tx_idx + 1'b1;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end

            default: tx_state <= S_IDLE;
         endcase
      end
   end

   assign tx_busy = (tx_state != S_IDLE);

endmodule
